// File: rtl/pdm_pkg.sv
// ============================================================================
// Module   : pdm_pkg
// Purpose  : Shared types and helper functions for the PDM modulator family.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pdm_pkg;

    // Slot counter wide enough for up to 16 TDM channels.
    typedef logic [3:0] pdm_slot_t;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [63:0] ACC_RESET(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pdm_edge_sync.sv
// ============================================================================
// Module   : pdm_edge_sync
// Purpose  : 2-FF synchroniser plus edge detector; one-clk strobe per edge
//            (rising only when DDR=0, both edges when DDR=1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pdm_edge_sync #(
    parameter int DDR = 1
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_async,
    output logic o_stb
);

    logic [1:0] r_sync;
    logic       r_prev;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync <= 2'b00;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_async};
            r_prev <= r_sync[1];
        end
    end

    generate
        if (DDR != 0) begin : g_ddr
            assign o_stb = r_sync[1] ^ r_prev;
        end else begin : g_sdr
            assign o_stb = r_sync[1] & ~r_prev;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/pdm_mc_modulator.sv
// ============================================================================
// Module   : pdm_mc_modulator
// Purpose  : NCH-channel TDM PDM modulator with double-buffered frame input.
//            Define PDM_MC_ORDER2_EN for second-order per-channel loops.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pdm_mc_modulator
    import pdm_pkg::*;
#(
    parameter int W   = 32,
    parameter int NCH = 2,
    parameter int DDR = 1
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        ock,
    input  logic [NCH*W-1:0]            in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        sdo,
    output logic [clog2_min1(NCH)-1:0]  sdo_ch,
    output logic                        underrun
);

    localparam int c_CW = clog2_min1(NCH);
    localparam int c_NS = 1 << c_CW;

    logic              w_stb;
    logic              w_last;
    logic              w_frame_start;
    logic [c_CW-1:0]   w_idx;
    logic [W-1:0]      w_din;
    logic              w_bit;

    logic [NCH*W-1:0]  r_pend;
    logic [NCH*W-1:0]  r_act;
    logic              r_pend_full;
    pdm_slot_t         r_slot;

    logic [W-1:0]      w_pend_ch [c_NS];
    logic [W-1:0]      w_act_ch  [c_NS];

    pdm_edge_sync #(.DDR(DDR)) u_sync (
        .clk     (clk),
        .rstn    (rstn),
        .i_async (ock),
        .o_stb   (w_stb)
    );

    assign w_idx         = r_slot[c_CW-1:0];
    assign w_last        = (r_slot == pdm_slot_t'(NCH - 1));
    assign w_frame_start = w_stb && (r_slot == '0);
    assign in_ready      = ~r_pend_full;

    // Channel views padded to a power of two so the slot index needs no range check.
    generate
        for (genvar g = 0; g < c_NS; g++) begin : g_ch
            if (g < NCH) begin : g_used
                assign w_pend_ch[g] = r_pend[g*W +: W];
                assign w_act_ch[g]  = r_act[g*W +: W];
            end else begin : g_pad
                assign w_pend_ch[g] = '0;
                assign w_act_ch[g]  = '0;
            end
        end
    endgenerate

    // Channel 0 must see the frame being transferred in this same cycle.
    assign w_din = (w_frame_start && r_pend_full) ? w_pend_ch[w_idx] : w_act_ch[w_idx];

`ifdef PDM_MC_ORDER2_EN
    localparam int c_IW = W + 4;
    localparam logic [W-1:0]             c_LO = {3'b001, {(W-3){1'b0}}};
    localparam logic [W-1:0]             c_HI = {3'b111, {(W-3){1'b0}}};
    localparam logic signed [c_IW-1:0]   c_FB = {4'b0001, {W{1'b0}}};

    logic signed [c_IW-1:0] r_i1 [c_NS];
    logic signed [c_IW-1:0] r_i2 [c_NS];
    logic [c_NS-1:0]        r_prev;
    logic [W-1:0]           w_clamp;
    logic signed [c_IW-1:0] w_fb;
    logic signed [c_IW-1:0] w_i1n;
    logic signed [c_IW-1:0] w_i2n;

    always_comb begin
        w_clamp = w_din;
        if (w_din < c_LO) begin
            w_clamp = c_LO;
        end else if (w_din > c_HI) begin
            w_clamp = c_HI;
        end
        w_fb  = r_prev[w_idx] ? c_FB : '0;
        w_i1n = r_i1[w_idx] + $signed({4'b0000, w_clamp}) - w_fb;
        w_i2n = r_i2[w_idx] + w_i1n - w_fb;
        w_bit = ~w_i2n[c_IW-1];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < c_NS; i++) begin
                r_i1[i] <= '0;
                r_i2[i] <= '0;
            end
            r_prev <= '0;
        end else if (w_stb) begin
            r_i1[w_idx]   <= w_i1n;
            r_i2[w_idx]   <= w_i2n;
            r_prev[w_idx] <= w_bit;
        end
    end
`else
    localparam logic [W-1:0] c_ACC_RST = W'(ACC_RESET(W));

    logic [W-1:0] r_acc [c_NS];
    logic [W:0]   w_sum;

    // The carry out of the shared adder is the quantised bit.
    always_comb begin
        w_sum = {1'b0, r_acc[w_idx]} + {1'b0, w_din};
        w_bit = w_sum[W];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < c_NS; i++) begin
                r_acc[i] <= c_ACC_RST;
            end
        end else if (w_stb) begin
            r_acc[w_idx] <= w_sum[W-1:0];
        end
    end
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pend      <= '0;
            r_act       <= '0;
            r_pend_full <= 1'b0;
            r_slot      <= '0;
            sdo         <= 1'b0;
            sdo_ch      <= '0;
            underrun    <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (in_valid && !r_pend_full) begin
                r_pend      <= in_data;
                r_pend_full <= 1'b1;
            end
            if (w_frame_start) begin
                if (r_pend_full) begin
                    r_act       <= r_pend;
                    r_pend_full <= 1'b0;
                end else begin
                    underrun <= 1'b1;
                end
            end
            if (w_stb) begin
                sdo    <= w_bit;
                sdo_ch <= w_idx;
                r_slot <= w_last ? '0 : r_slot + pdm_slot_t'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pdm_mc_modulator.sv
// ============================================================================
// Module   : tb_pdm_mc_modulator
// Purpose  : Self-checking bench: a mono SDR and a stereo DDR instance checked
//            against a frame/slot-level arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pdm_mc_modulator;

    localparam int HALF = 6;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic ock  = 1'b0;

    logic [7:0]  in_data1  = '0;
    logic        in_valid1 = 1'b0;
    logic        in_ready1, sdo1, underrun1;
    logic [0:0]  sdo_ch1;
    logic [15:0] in_data2  = '0;
    logic        in_valid2 = 1'b0;
    logic        in_ready2, sdo2, underrun2;
    logic [0:0]  sdo_ch2;

    always #5 clk = ~clk;

    pdm_mc_modulator #(.W(8), .NCH(1), .DDR(0)) u_mono (
        .clk(clk), .rstn(rstn), .ock(ock),
        .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
        .sdo(sdo1), .sdo_ch(sdo_ch1), .underrun(underrun1)
    );

    pdm_mc_modulator #(.W(8), .NCH(2), .DDR(1)) u_tdm (
        .clk(clk), .rstn(rstn), .ock(ock),
        .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
        .sdo(sdo2), .sdo_ch(sdo_ch2), .underrun(underrun2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model state, index 0 = mono instance, 1 = stereo instance.
    int m_acc  [2][2];
    int m_act  [2][2];
    int m_pend [2][2];
    bit m_pf   [2];
    int m_slot [2];
    int m_sdo  [2];
    int m_ch   [2];
    int m_ur   [2] = '{0, 0};
    int o_ur   [2] = '{0, 0};
    int nch    [2] = '{1, 2};

    always @(posedge clk) begin
        if (underrun1 === 1'b1) o_ur[0]++;
        if (underrun2 === 1'b1) o_ur[1]++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset(input int d);
        for (int c = 0; c < 2; c++) begin
            m_acc[d][c]  = 128;
            m_act[d][c]  = 0;
            m_pend[d][c] = 0;
        end
        m_pf[d] = 1'b0; m_slot[d] = 0; m_sdo[d] = 0; m_ch[d] = 0;
    endtask

    task automatic model_slot(input int d);
        int c, s;
        if (m_slot[d] == 0) begin
            if (m_pf[d]) begin
                m_act[d] = m_pend[d];
                m_pf[d]  = 1'b0;
            end else begin
                m_ur[d]++;
            end
        end
        c = m_slot[d];
        s = m_acc[d][c] + m_act[d][c];
        m_sdo[d]    = s / 256;
        m_acc[d][c] = s % 256;
        m_ch[d]     = c;
        m_slot[d]   = (c + 1) % nch[d];
    endtask

    task automatic compare_all();
        chk("mono.sdo",      {31'd0, sdo1},      m_sdo[0]);
        chk("mono.sdo_ch",   {31'd0, sdo_ch1},   m_ch[0]);
        chk("mono.in_ready", {31'd0, in_ready1}, {31'd0, !m_pf[0]});
        chk("mono.underrun_count", o_ur[0], m_ur[0]);
        chk("tdm.sdo",       {31'd0, sdo2},      m_sdo[1]);
        chk("tdm.sdo_ch",    {31'd0, sdo_ch2},   m_ch[1]);
        chk("tdm.in_ready",  {31'd0, in_ready2}, {31'd0, !m_pf[1]});
        chk("tdm.underrun_count", o_ur[1], m_ur[1]);
    endtask

    // One ock phase: optional frame offers, then an ock toggle, then a check.
    task automatic tick(input bit o1, input logic [7:0] x1, input bit o2, input logic [15:0] x2);
        if (o1) begin in_valid1 = 1'b1; in_data1 = x1; end
        if (o2) begin in_valid2 = 1'b1; in_data2 = x2; end
        @(negedge clk);
        in_valid1 = 1'b0;
        in_valid2 = 1'b0;
        if (o1 && !m_pf[0]) begin m_pend[0][0] = x1; m_pf[0] = 1'b1; end
        if (o2 && !m_pf[1]) begin
            m_pend[1][0] = x2[7:0];
            m_pend[1][1] = x2[15:8];
            m_pf[1]      = 1'b1;
        end
        ock = ~ock;
        if (ock) model_slot(0);
        model_slot(1);
        repeat (HALF) @(negedge clk);
        compare_all();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".mono.sdo"},      {31'd0, sdo1},      0);
        chk({tag, ".mono.sdo_ch"},   {31'd0, sdo_ch1},   0);
        chk({tag, ".mono.in_ready"}, {31'd0, in_ready1}, 1);
        chk({tag, ".mono.underrun"}, {31'd0, underrun1}, 0);
        chk({tag, ".tdm.sdo"},       {31'd0, sdo2},      0);
        chk({tag, ".tdm.sdo_ch"},    {31'd0, sdo_ch2},   0);
        chk({tag, ".tdm.in_ready"},  {31'd0, in_ready2}, 1);
        chk({tag, ".tdm.underrun"},  {31'd0, underrun2}, 0);
    endtask

    task automatic do_reset();
        #3 rstn = 1'b0;
        #1 check_reset_values("async_reset");
        ock       = 1'b0;
        in_valid1 = 1'b0;
        in_valid2 = 1'b0;
        model_reset(0);
        model_reset(1);
        repeat (4) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // 0x40 from a fresh start: slots 1..8 must read 0,1,0,0,0,1,0,0.
    task automatic pattern_check(input string tag);
        logic [7:0] seen;
        int k;
        seen = '0;
        k    = 0;
        for (int i = 0; i < 16; i++) begin
            tick(i == 0, 8'h40, i == 0, 16'h00FF);
            if (ock) begin
                seen[k] = sdo1;
                k++;
            end
        end
        chk({tag, ".mono_0x40_pattern"}, {24'd0, seen}, 32'h22);
        chk({tag, ".model_acc_after_8"}, m_acc[0][0], 128);
    endtask

    initial begin
        int ones1, ones_ch0, ones_ch1, ur0_base, ur1_base;
        model_reset(0);
        model_reset(1);
        repeat (3) @(negedge clk);
        check_reset_values("power_on");
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        chk("power_on.mono.in_ready_after_release", {31'd0, in_ready1}, 1);

        pattern_check("fresh");

        // Zero frame: no ones at all.
        ones1 = 0;
        for (int i = 0; i < 8; i++) begin
            tick(i == 0, 8'h00, 1'b0, 16'h0);
            if (ock) ones1 += int'(sdo1);
        end
        chk("mono.zero_density", ones1, 0);

        // Full-scale frame on mono; stereo keeps its held 0xFF/0x00 frame.
        ones1 = 0; ones_ch0 = 0; ones_ch1 = 0;
        ur0_base = o_ur[0];
        ur1_base = o_ur[1];
        for (int i = 0; i < 512; i++) begin
            tick(i == 0, 8'hFF, 1'b0, 16'h0);
            if (ock) ones1 += int'(sdo1);
            if (sdo_ch2 == 1'b0) ones_ch0 += int'(sdo2);
            else                 ones_ch1 += int'(sdo2);
        end
        chk("mono.fullscale_ones_in_256", ones1, 255);
        chk("model.acc_after_fullscale", m_acc[0][0], 128);
        chk("tdm.ch0_ones_in_256", ones_ch0, 255);
        chk("tdm.ch1_ones", ones_ch1, 0);
        chk("mono.underruns_in_256", o_ur[0] - ur0_base, 255);
        chk("tdm.underruns_in_256", o_ur[1] - ur1_base, 256);

        for (int i = 0; i < 300; i++) begin
            tick($urandom_range(0, 3) == 0, 8'($urandom),
                 $urandom_range(0, 3) == 0, 16'($urandom));
        end

        do_reset();
        pattern_check("after_reset");

        for (int i = 0; i < 300; i++) begin
            tick($urandom_range(0, 2) == 0, 8'($urandom),
                 $urandom_range(0, 2) == 0, 16'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
